// File: rtl/grayscale_converter_arbiter_if.sv
// Bus bundle for the grayscale arbiter: CPU custom-instruction port, camera pixel
// stream in/out, and the shared converter port. "slave" is the arbiter's view.
interface grayscale_converter_arbiter_if;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;

    logic        pixelValid;
    logic [31:0] pixelWordA;
    logic [31:0] pixelWordB;
    logic        pixelReady;
    logic        grayValid;
    logic [31:0] grayWord;
    logic        grayReady;

    logic        convStart;
    logic [7:0]  convIseId;
    logic [31:0] convValueA;
    logic [31:0] convValueB;
    logic        convDone;
    logic [31:0] convResult;

    modport master (
        output ciStart, ciN, ciValueA, ciValueB,
        input  ciDone, ciResult,
        output pixelValid, pixelWordA, pixelWordB, grayReady,
        input  pixelReady, grayValid, grayWord,
        input  convStart, convIseId, convValueA, convValueB,
        output convDone, convResult
    );

    modport slave (
        input  ciStart, ciN, ciValueA, ciValueB,
        output ciDone, ciResult,
        input  pixelValid, pixelWordA, pixelWordB, grayReady,
        output pixelReady, grayValid, grayWord,
        output convStart, convIseId, convValueA, convValueB,
        input  convDone, convResult
    );
endinterface

// File: rtl/grayscale_converter_arbiter.sv
// Shares one combinational RGB565->gray converter between the CPU CI port and the
// camera stream; the CPU is forced in after MAX_STREAM_BURST consecutive stream grants.
module grayscale_converter_arbiter #(
    parameter logic [7:0]  customInstructionId = 8'd13,
    parameter int unsigned MAX_STREAM_BURST    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    grayscale_converter_arbiter_if.slave  bus
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_STREAM_BURST);

    logic        r_cpu_pending;
    logic [31:0] r_cpu_a;
    logic [31:0] r_cpu_b;
    logic        r_ci_done;
    logic [31:0] r_ci_result;
    logic        r_gray_valid;
    logic [31:0] r_gray_word;
    logic [7:0]  r_burst_cnt;

    logic        w_new_req;
    logic        w_cpu_req;
    logic        w_stream_ok;
    logic        w_cpu_grant;
    logic        w_stream_grant;
    logic        w_cpu_capture;
    logic        w_gray_load;
    logic [31:0] w_conv_a;
    logic [31:0] w_conv_b;

    // Grants are suppressed while reset is held so the converter stays idle.
    assign w_new_req      = bus.ciStart & (bus.ciN == customInstructionId) & ~r_cpu_pending;
    assign w_cpu_req      = reset & (r_cpu_pending | w_new_req);
    assign w_stream_ok    = reset & bus.pixelValid & (~r_gray_valid | bus.grayReady);
    assign w_cpu_grant    = w_cpu_req & (~w_stream_ok | (r_burst_cnt == BURST_MAX));
    assign w_stream_grant = w_stream_ok & ~w_cpu_grant;
    assign w_cpu_capture  = w_cpu_grant & bus.convDone;
    assign w_gray_load    = w_stream_grant & bus.convDone;

    always_comb begin
        w_conv_a = '0;
        w_conv_b = '0;
        if (w_cpu_grant) begin
            w_conv_a = r_cpu_pending ? r_cpu_a : bus.ciValueA;
            w_conv_b = r_cpu_pending ? r_cpu_b : bus.ciValueB;
        end else if (w_stream_grant) begin
            w_conv_a = bus.pixelWordA;
            w_conv_b = bus.pixelWordB;
        end
    end

    assign bus.convStart  = w_cpu_grant | w_stream_grant;
    assign bus.convIseId  = bus.convStart ? customInstructionId : 8'd0;
    assign bus.convValueA = w_conv_a;
    assign bus.convValueB = w_conv_b;
    assign bus.pixelReady = w_stream_grant;
    assign bus.ciDone     = r_ci_done;
    assign bus.ciResult   = r_ci_result;
    assign bus.grayValid  = r_gray_valid;
    assign bus.grayWord   = r_gray_word;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cpu_pending <= 1'b0;
            r_cpu_a       <= '0;
            r_cpu_b       <= '0;
            r_ci_done     <= 1'b0;
            r_ci_result   <= '0;
            r_gray_valid  <= 1'b0;
            r_gray_word   <= '0;
            r_burst_cnt   <= '0;
        end else begin
            if (w_cpu_grant) begin
                r_cpu_pending <= 1'b0;
            end else if (w_new_req) begin
                r_cpu_pending <= 1'b1;
                r_cpu_a       <= bus.ciValueA;
                r_cpu_b       <= bus.ciValueB;
            end

            r_ci_done   <= w_cpu_capture;
            r_ci_result <= w_cpu_capture ? bus.convResult : 32'd0;

            // A refill wins over a drain, so drain+refill keeps the register full.
            if (w_gray_load) begin
                r_gray_valid <= 1'b1;
                r_gray_word  <= bus.convResult;
            end else if (r_gray_valid && bus.grayReady) begin
                r_gray_valid <= 1'b0;
            end

            if (!w_cpu_req || w_cpu_grant) begin
                r_burst_cnt <= '0;
            end else if (w_stream_grant && (r_burst_cnt != BURST_MAX)) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_grayscale_converter_arbiter.sv
// Bench for grayscale_converter_arbiter: behavioural RGB565->gray converter, a vector
// table for single-cycle behaviour, hand sequences for burst, stall and reset cases.
module tb_grayscale_converter_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grayscale_converter_arbiter_if bus();

    grayscale_converter_arbiter dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    bit          mon_en    = 1'b0;
    logic [31:0] cpu_q[$];
    logic [31:0] gray_q[$];
    logic [31:0] mon_exp;
    logic [31:0] ca, cb, w1, w2, tpa, tpb;

    // Per-channel truncated weights (54/183/19 over 256) on 8-bit expanded channels.
    function automatic logic [7:0] px_gray(input logic [15:0] p);
        logic [15:0] tr, tg, tbl;
        tr  = {8'd0, p[15:11], 3'b000} * 16'd54;
        tg  = {8'd0, p[10:5], 2'b00} * 16'd183;
        tbl = {8'd0, p[4:0], 3'b000} * 16'd19;
        return tr[15:8] + tg[15:8] + tbl[15:8];
    endfunction

    function automatic logic [31:0] conv_ref(input logic [31:0] a, input logic [31:0] b);
        return {px_gray(b[31:16]), px_gray(b[15:0]), px_gray(a[31:16]), px_gray(a[15:0])};
    endfunction

    assign bus.convDone   = bus.convStart;
    assign bus.convResult = conv_ref(bus.convValueA, bus.convValueB);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic [7:0] cn, input logic [31:0] a,
                         input logic [31:0] b, input logic pv, input logic [31:0] pa,
                         input logic [31:0] pb, input logic gr);
        bus.ciStart    = cs;
        bus.ciN        = cn;
        bus.ciValueA   = a;
        bus.ciValueB   = b;
        bus.pixelValid = pv;
        bus.pixelWordA = pa;
        bus.pixelWordB = pb;
        bus.grayReady  = gr;
    endtask

    // Scoreboard: pops on ciDone / gray drain, pushes stream expectations on pixelReady.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ciDone) begin
                if (cpu_q.size() == 0) begin
                    check("ciDone_unexpected", 32'(bus.ciDone), 32'd0);
                end else begin
                    mon_exp = cpu_q.pop_front();
                    $display("ci   result=%h expected=%h", bus.ciResult, mon_exp);
                    check("ciResult", bus.ciResult, mon_exp);
                end
            end else begin
                check("ciResult_idle", bus.ciResult, 32'd0);
            end
            if (bus.grayValid && bus.grayReady) begin
                if (gray_q.size() == 0) begin
                    check("gray_unexpected", 32'(bus.grayValid), 32'd0);
                end else begin
                    mon_exp = gray_q.pop_front();
                    $display("gray word=%h expected=%h", bus.grayWord, mon_exp);
                    check("grayWord", bus.grayWord, mon_exp);
                end
            end
            if (bus.pixelReady) gray_q.push_back(conv_ref(bus.pixelWordA, bus.pixelWordB));
        end
    end

    typedef struct {
        logic        cs;
        logic [7:0]  cn;
        logic [31:0] a, b;
        logic        pv;
        logic [31:0] pa, pb;
        logic        gr;
        logic        push_ci;
        logic [31:0] exp_ci;
        logic        e_ready, e_start;
        logic [7:0]  e_ise;
        logic        e_done, e_gv;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // fields: cs cn a b pv pa pb gr push exp_ci ready start ise done gv
        vecs[0] = '{1'b1, 8'd13, 32'h84104208, 32'hffffc618, 1'b0, 32'h0, 32'h0, 1'b1,
                    1'b1, 32'hfabf7f3e, 1'b0, 1'b1, 8'd13, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1,
                    1'b0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'd47, 32'h84104208, 32'hffffc618, 1'b0, 32'h0, 32'h0, 1'b1,
                    1'b0, 32'h0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[3] = vecs[1];
        vecs[4] = '{1'b0, 8'd0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1,
                    1'b0, 32'h0, 1'b1, 1'b1, 8'd13, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'd0, 32'h0, 32'h0, 1'b1, 32'hffffffff, 32'hffffffff, 1'b1,
                    1'b0, 32'h0, 1'b1, 1'b1, 8'd13, 1'b0, 1'b1};
        vecs[6] = vecs[1];
        vecs[7] = vecs[1];
        vecs[8] = '{1'b1, 8'd13, 32'h00ff1234, 32'hf80007e0, 1'b1, 32'h5a5a0f0f, 32'h1234abcd, 1'b1,
                    1'b1, conv_ref(32'h00ff1234, 32'hf80007e0), 1'b1, 1'b1, 8'd13, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1,
                    1'b0, 32'h0, 1'b0, 1'b1, 8'd13, 1'b1, 1'b0};

        // Reset held two cycles with requests present.
        drive(1'b1, 8'd13, 32'h84104208, 32'hffffc618, 1'b1, 32'h12345678, 32'h9abcdef0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("rst_convStart", 32'(bus.convStart), 32'd0);
            check("rst_pixelReady", 32'(bus.pixelReady), 32'd0);
            tick();
        end
        check("rst_ciDone", 32'(bus.ciDone), 32'd0);
        check("rst_ciResult", bus.ciResult, 32'd0);
        check("rst_grayValid", 32'(bus.grayValid), 32'd0);
        check("rst_grayWord", bus.grayWord, 32'd0);
        drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
        check("post_rst_ciDone", 32'(bus.ciDone), 32'd0);
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].cs, vecs[i].cn, vecs[i].a, vecs[i].b, vecs[i].pv,
                  vecs[i].pa, vecs[i].pb, vecs[i].gr);
            if (vecs[i].push_ci) cpu_q.push_back(vecs[i].exp_ci);
            @(negedge clk);
            check($sformatf("v%0d_pixelReady", i), 32'(bus.pixelReady), 32'(vecs[i].e_ready));
            check($sformatf("v%0d_convStart", i), 32'(bus.convStart), 32'(vecs[i].e_start));
            check($sformatf("v%0d_convIseId", i), 32'(bus.convIseId), 32'(vecs[i].e_ise));
            tick();
            check($sformatf("v%0d_ciDone", i), 32'(bus.ciDone), 32'(vecs[i].e_done));
            check($sformatf("v%0d_grayValid", i), 32'(bus.grayValid), 32'(vecs[i].e_gv));
        end

        // Continuous stream contending with a CPU request: 4 stream grants, then CPU.
        ca = $urandom;
        cb = $urandom;
        for (int c = 0; c < 6; c++) begin
            tpa = $urandom;
            tpb = $urandom;
            if (c == 0) begin
                drive(1'b1, 8'd13, ca, cb, 1'b1, tpa, tpb, 1'b1);
                cpu_q.push_back(conv_ref(ca, cb));
            end else if (c == 2) begin
                drive(1'b1, 8'd13, ~ca, ~cb, 1'b1, tpa, tpb, 1'b1);
            end else begin
                drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b1, tpa, tpb, 1'b1);
            end
            @(negedge clk);
            check("burst_pixelReady", 32'(bus.pixelReady), (c == 4) ? 32'd1 - 32'd1 : 32'd1);
            check("burst_convStart", 32'(bus.convStart), 32'd1);
            tick();
            check("burst_ciDone", 32'(bus.ciDone), (c == 4) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        check("burst_drained", 32'(bus.grayValid), 32'd0);

        // Stalled stream: word held, CPU served in one cycle, then drain+refill.
        w1 = $urandom;
        w2 = $urandom;
        drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b1, w1, ~w1, 1'b1);
        tick();
        check("stall_load_word", bus.grayWord, conv_ref(w1, ~w1));
        ca = $urandom;
        cb = $urandom;
        drive(1'b1, 8'd13, ca, cb, 1'b1, w2, ~w2, 1'b0);
        cpu_q.push_back(conv_ref(ca, cb));
        @(negedge clk);
        check("stall_pixelReady", 32'(bus.pixelReady), 32'd0);
        check("stall_cpu_convStart", 32'(bus.convStart), 32'd1);
        tick();
        check("stall_ciDone", 32'(bus.ciDone), 32'd1);
        check("stall_word_held1", bus.grayWord, conv_ref(w1, ~w1));
        drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b1, w2, ~w2, 1'b0);
        @(negedge clk);
        check("stall_idle_convStart", 32'(bus.convStart), 32'd0);
        tick();
        check("stall_ciDone_pulse", 32'(bus.ciDone), 32'd0);
        check("stall_valid_held", 32'(bus.grayValid), 32'd1);
        check("stall_word_held2", bus.grayWord, conv_ref(w1, ~w1));
        drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b1, w2, ~w2, 1'b1);
        @(negedge clk);
        check("refill_pixelReady", 32'(bus.pixelReady), 32'd1);
        tick();
        check("refill_valid", 32'(bus.grayValid), 32'd1);
        check("refill_word", bus.grayWord, conv_ref(w2, ~w2));
        drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        check("final_drain_valid", 32'(bus.grayValid), 32'd0);

        // Reset with a pending CPU request and a held gray word.
        drive(1'b1, 8'd13, $urandom, $urandom, 1'b1, $urandom, $urandom, 1'b1);
        @(negedge clk);
        check("pre_rst_pixelReady", 32'(bus.pixelReady), 32'd1);
        tick();
        check("pre_rst_grayValid", 32'(bus.grayValid), 32'd1);
        drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_convStart", 32'(bus.convStart), 32'd0);
        tick();
        gray_q.delete();
        check("mid_rst_grayValid", 32'(bus.grayValid), 32'd0);
        check("mid_rst_grayWord", bus.grayWord, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_ciDone", 32'(bus.ciDone), 32'd0);
        end
        ca = $urandom;
        cb = $urandom;
        drive(1'b1, 8'd13, ca, cb, 1'b0, 32'h0, 32'h0, 1'b1);
        cpu_q.push_back(conv_ref(ca, cb));
        tick();
        check("post_rst_cpu_ciDone", 32'(bus.ciDone), 32'd1);
        drive(1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        tick();

        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        check("gray_q_empty", 32'(gray_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
